// File: rtl/trace_seq_pkg.sv
// Shared types and constants for the acquisition trace sequencer.
// Holds the FSM state encoding, LFSR taps and capture record layout.
package trace_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        APPLY,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    localparam int TAP_A = 0;
    localparam int TAP_B = 2;
    localparam int TAP_C = 3;
    localparam int TAP_D = 5;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D];
        return {fb, l[15:1]};
    endfunction

    // Record layout, MSB first: {class, vector, dut_out}
    function automatic int cap_vec_lsb(input int out_size);
        return out_size;
    endfunction

    function automatic int cap_cls_bit(input int in_size, input int out_size);
        return in_size + out_size;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR mask source.
// Advances only when step is high; reset loads the seed.
module lfsr16
    import trace_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // Shift register: reseed on reset, advance on step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/trace_sequencer.sv
// Sequences a masked-gate DUT through a campaign of acquisition traces.
// Per trace: precharge, apply vector, trigger, settle, hand record to logger.
module trace_sequencer
    import trace_seq_pkg::*;
#(
    parameter int          DW            = 2,
    parameter int          MW            = 2,
    parameter int          IN_SIZE       = DW + MW,
    parameter int          OUT_SIZE      = 1,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          TCW           = 16,
    parameter logic [15:0] SEED          = SEED_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [TCW-1:0]               n_traces,
    input  logic                         fixed_en,
    input  logic [DW-1:0]                fixed_val,
    output logic [IN_SIZE-1:0]           dut_in,
    input  logic [OUT_SIZE-1:0]          dut_out,
    output logic                         trig,
    output logic                         busy,
    output logic                         done,
    output logic                         cap_valid,
    input  logic                         cap_ready,
    output logic [IN_SIZE+OUT_SIZE:0]    cap_data,
    output logic [TCW-1:0]               trace_cnt
);

    localparam int VEC_LSB = cap_vec_lsb(OUT_SIZE);
    localparam int CLS_BIT = cap_cls_bit(IN_SIZE, OUT_SIZE);
    localparam int SCW     = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

    state_t               state_q;
    state_t               state_d;
    logic [15:0]          lfsr_q;
    logic [15:0]          l_step;
    logic                 lfsr_unused;
    logic [TCW-1:0]       n_lat;
    logic                 fixed_en_q;
    logic [DW-1:0]        fixed_val_q;
    logic                 cls_q;
    logic                 cls_b;
    logic [IN_SIZE-1:0]   vec_b;
    logic [SCW-1:0]       set_cnt;
    logic [IN_SIZE-1:0]   dut_in_q;
    logic [CLS_BIT:0]     cap_data_q;
    logic [TCW-1:0]       cnt_q;
    logic [TCW-1:0]       cnt_inc;
    logic                 hs;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (state_q == LOAD),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    assign l_step      = lfsr_next(lfsr_q);
    assign lfsr_unused = ^l_step;
    assign hs          = (state_q == CAPTURE) && cap_ready;
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + TCW'(1);

    // Vector built from the value the LFSR steps to during LOAD
    always_comb begin
        cls_b = fixed_en_q & l_step[15];
        vec_b = l_step[IN_SIZE-1:0];
        if (cls_b) begin
            vec_b[IN_SIZE-1:MW] = fixed_val_q;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !abort) state_d = LOAD;
            LOAD:    state_d = APPLY;
            APPLY:   state_d = SETTLE;
            SETTLE:  if (set_cnt == SETTLE_LAST) state_d = CAPTURE;
            CAPTURE: if (cap_ready) state_d = (cnt_inc == n_lat) ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    // Status strobes decoded from the current state
    always_comb begin
        busy      = 1'b0;
        trig      = 1'b0;
        cap_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE:    busy = 1'b0;
            APPLY:   begin busy = 1'b1; trig = 1'b1; end
            CAPTURE: begin busy = 1'b1; cap_valid = 1'b1; end
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: busy = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Campaign config, settle timer, DUT drive, record and trace count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_lat       <= '0;
            fixed_en_q  <= 1'b0;
            fixed_val_q <= '0;
            cls_q       <= 1'b0;
            set_cnt     <= '0;
            dut_in_q    <= '0;
            cap_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            if (state_q == IDLE && state_d == LOAD) begin
                n_lat       <= (n_traces == '0) ? TCW'(1) : n_traces;
                fixed_en_q  <= fixed_en;
                fixed_val_q <= fixed_val;
                cnt_q       <= '0;
            end
            if (state_q == LOAD) begin
                cls_q <= cls_b;
            end
            if (state_q == SETTLE && state_d == SETTLE) begin
                set_cnt <= set_cnt + SCW'(1);
            end else begin
                set_cnt <= '0;
            end
            case (state_d)
                APPLY:   dut_in_q <= vec_b;
                SETTLE:  dut_in_q <= dut_in_q;
                CAPTURE: dut_in_q <= dut_in_q;
                default: dut_in_q <= '0;
            endcase
            if (state_q == SETTLE && state_d == CAPTURE) begin
                cap_data_q[CLS_BIT]           <= cls_q;
                cap_data_q[CLS_BIT-1:VEC_LSB] <= dut_in_q;
                cap_data_q[VEC_LSB-1:0]       <= dut_out;
            end
            if (hs && !abort) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign dut_in    = dut_in_q;
    assign cap_data  = cap_data_q;
    assign trace_cnt = cnt_q;

endmodule

// File: tb/tb_trace_sequencer.sv
// Scoreboard bench for trace_sequencer.
// Expected records come from an independent LFSR model.
module tb_trace_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] n_traces;
    logic        fixed_en;
    logic [1:0]  fixed_val;
    logic [3:0]  dut_in;
    logic [0:0]  dut_out;
    logic        trig;
    logic        busy;
    logic        done;
    logic        cap_valid;
    logic        cap_ready;
    logic [5:0]  cap_data;
    logic [15:0] trace_cnt;

    always #5 clk = ~clk;

    assign dut_out = ^dut_in;

    trace_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .n_traces  (n_traces),
        .fixed_en  (fixed_en),
        .fixed_val (fixed_val),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .trig      (trig),
        .busy      (busy),
        .done      (done),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .cap_data  (cap_data),
        .trace_cnt (trace_cnt)
    );

    typedef struct {
        logic        cls;
        logic [3:0]  vec;
        logic [15:0] l;
    } rec_t;

    rec_t        sb[$];
    logic [15:0] m_l;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_trig = -1;
    int          done_cnt = 0;
    int          trig_cnt = 0;
    bit          spacing_on = 0;
    logic        prev_trig = 0;
    logic        prev_valid = 0;
    logic [3:0]  prev_dut = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // One clock; then monitor the outputs 1 time unit after the edge
    task automatic step();
        rec_t r;
        @(posedge clk);
        #1;
        cyc++;
        if (trig) begin
            trig_cnt++;
            check("trig_width", prev_trig, 0);
            check("precharge", prev_dut, 0);
            if (sb.size() > 0) check("trig_vec", dut_in, sb[0].vec);
            else check("trig_sb_size", sb.size(), 1);
            if (spacing_on && last_trig >= 0)
                check("trig_space", cyc - last_trig, 7);
            last_trig = cyc;
        end
        if (cap_valid && !prev_valid) begin
            if (sb.size() > 0) begin
                r = sb.pop_front();
                check("cap_data", cap_data, {r.cls, r.vec, ^r.vec});
            end else begin
                check("cap_sb_size", sb.size(), 1);
            end
        end
        if (done) done_cnt++;
        prev_trig  = trig;
        prev_valid = cap_valid;
        prev_dut   = dut_in;
    endtask

    task automatic start_campaign(input int n, input logic fe,
                                  input logic [1:0] fv);
        rec_t r;
        int   nn;
        n_traces  = 16'(n);
        fixed_en  = fe;
        fixed_val = fv;
        start     = 1'b1;
        nn = (n == 0) ? 1 : n;
        for (int i = 0; i < nn; i++) begin
            m_l   = m_step(m_l);
            r.l   = m_l;
            r.cls = fe & m_l[15];
            r.vec = {r.cls ? fv : m_l[3:2], m_l[1:0]};
            sb.push_back(r);
        end
        last_trig = -1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cnt);
        bit seen = 0;
        int k = 0;
        while (!seen && k < 300) begin
            step();
            k++;
            if (done) begin
                seen = 1;
                check("done_cnt", trace_cnt, exp_cnt);
                check("done_busy", busy, 1);
            end
        end
        check("done_seen", seen, 1);
        step();
        check("done_width", done, 0);
        check("idle_busy", busy, 0);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        logic [5:0]  d0;
        logic [3:0]  v0;
        int          dc0;
        int          k;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        n_traces  = '0;
        fixed_en  = 1'b0;
        fixed_val = '0;
        cap_ready = 1'b1;
        m_l       = 16'hACE1;
        repeat (3) step();
        check("rst_dut_in", dut_in, 0);
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", cap_valid, 0);
        check("rst_cap", cap_data, 0);
        check("rst_cnt", trace_cnt, 0);
        rst_n = 1'b1;
        step();

        spacing_on = 1;
        start_campaign(2, 1'b0, 2'b00);
        check("load_busy", busy, 1);
        check("load_dut_in", dut_in, 0);
        wait_done(2);

        start_campaign(3, 1'b0, 2'b00);
        wait_done(3);

        start_campaign(8, 1'b1, 2'b11);
        wait_done(8);

        spacing_on = 0;
        cap_ready  = 1'b0;
        start_campaign(2, 1'b0, 2'b00);
        k = 0;
        while (!cap_valid && k < 50) begin
            step();
            k++;
        end
        check("stall_reach", cap_valid, 1);
        d0 = cap_data;
        v0 = dut_in;
        repeat (5) begin
            step();
            check("stall_valid", cap_valid, 1);
            check("stall_data", cap_data, d0);
            check("stall_cnt", trace_cnt, 0);
            check("stall_trig", trig, 0);
            check("stall_dut", dut_in, v0);
        end
        cap_ready = 1'b1;
        step();
        check("stall_rel_cnt", trace_cnt, 1);
        check("stall_rel_valid", cap_valid, 0);
        wait_done(2);

        spacing_on = 1;
        trig_cnt   = 0;
        start_campaign(3, 1'b0, 2'b00);
        k = 0;
        while (trig_cnt < 2 && k < 100) begin
            step();
            k++;
        end
        check("abort_reach", trig_cnt, 2);
        step();
        dc0   = done_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_dut", dut_in, 0);
        check("abort_valid", cap_valid, 0);
        check("abort_trig", trig, 0);
        check("abort_cnt", trace_cnt, 1);
        repeat (5) step();
        check("abort_no_done", done_cnt, dc0);
        check("abort_cnt_hold", trace_cnt, 1);
        if (sb.size() > 0) m_l = sb[0].l;
        sb.delete();
        start_campaign(1, 1'b0, 2'b00);
        check("restart_cnt", trace_cnt, 0);
        wait_done(1);

        start_campaign(0, 1'b0, 2'b00);
        wait_done(1);

        n_traces = 16'd5;
        start    = 1'b1;
        abort    = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy0", busy, 0);
        step();
        check("sa_busy1", busy, 0);
        check("sa_trig", trig, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trace_sequencer.md
Name: trace_sequencer

Overview:
- Controller that sequences the masked-gate DUT through a programmed number of acquisition traces.
- Per trace it:
  - precharges the DUT inputs to zero;
  - applies a vector of data shares (a, b) and fresh masks (r1, r2) drawn from an LFSR;
  - raises a one-cycle scope trigger and waits a settle window;
  - hands the captured DUT output, the vector and the class label to the logger over a valid/ready handshake.
- Supports random-only and fixed-vs-random (TVLA) campaigns.

Parameters:
- DW, 2, data-share width; dut_in[IN_SIZE-1:MW] = {a, b}
- MW, 2, mask width; dut_in[MW-1:0] = {r1, r2}
- IN_SIZE, DW+MW, DUT input width (4 = {a, b, r1, r2})
- OUT_SIZE, 1, DUT output width
- SETTLE_CYCLES, 4, cycles held in SETTLE before capture (>=1)
- TCW, 16, trace counter width
- SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin campaign; honoured only in IDLE
- abort  in  1  terminate campaign; return to IDLE
- n_traces  in  TCW  trace count, sampled at start; 0 treated as 1
- fixed_en  in  1  fixed-vs-random mode, sampled at start
- fixed_val  in  DW  fixed-class data value, sampled at start
- dut_in  out  IN_SIZE  registered DUT input vector
- dut_out  in  OUT_SIZE  DUT output
- trig  out  1  scope trigger
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at campaign end
- cap_valid  out  1  capture record valid
- cap_ready  in  1  logger accepts record
- cap_data  out  1+IN_SIZE+OUT_SIZE  {class, vector, dut_out}
- trace_cnt  out  TCW  traces completed

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all outputs 0;
  - state=IDLE;
  - LFSR=SEED;
  - settle counter 0.
- LFSR:
  - 16-bit Fibonacci; fb = l[0]^l[2]^l[3]^l[5]; next l = {fb, l[15:1]};
  - steps exactly once per LOAD, otherwise holds;
  - start does not reseed it.
- IDLE -> LOAD on start=1 and abort=0:
  - latch n_traces, fixed_en, fixed_val;
  - clear trace_cnt.
- LOAD (1 cycle):
  - dut_in=0 (precharge);
  - LFSR steps;
  - vector register built from the stepped value L:
    - class = fixed_en & L[15];
    - data = class ? fixed_val : L[IN_SIZE-1:MW];
    - masks = L[MW-1:0].
  - -> APPLY.
- APPLY (1 cycle): dut_in=vector; trig=1 this cycle only; -> SETTLE.
- SETTLE: dut_in held; stay SETTLE_CYCLES cycles; -> CAPTURE.
- CAPTURE:
  - on entry, cap_data={class, vector, dut_out}, sampled at the SETTLE->CAPTURE edge;
  - cap_valid=1; cap_data stable until handshake.
- Handshake cap_valid & cap_ready:
  - trace_cnt+1;
  - if the new count == latched n_traces -> DONE, else -> LOAD;
  - cap_valid drops the following cycle.
- DONE (1 cycle): done=1; dut_in=0; -> IDLE.
- Per-trace latency with cap_ready=1: SETTLE_CYCLES+3 cycles.
  - Trig-to-trig spacing is the same value.
- abort:
  - in any non-IDLE state -> IDLE next cycle;
  - cap_valid, trig, dut_in go to 0;
  - done is not asserted; trace_cnt holds.
- start+abort in IDLE: abort wins, stay IDLE.
- start while busy: ignored.
- trace_cnt saturates at 2^TCW-1; campaign ends when it reaches n_traces.
- Reset mid-campaign: immediate return to reset values, LFSR reseeded.

Decomposition:
- Package trace_seq_pkg:
  - state enum {IDLE, LOAD, APPLY, SETTLE, CAPTURE, DONE};
  - LFSR tap constants;
  - SEED default;
  - cap_data field offsets.
- Sub-module lfsr16 (clk, rst_n, step, seed, q).
- FSM, vector build and capture register stay in trace_sequencer.

Test Plan:
- Reset, then start with n_traces=2, fixed_en=0, cap_ready=1 -> dut_in sequence:
  - 0x0 precharge, then vector 0x0 (L=0x5670);
  - next trace vector 0x8 (L=0xAB38);
  - cap_data class bits 0; done pulse; trace_cnt=2.
- SETTLE_CYCLES=4, n_traces=3 -> trig pulses exactly 7 cycles apart, each 1 cycle wide; busy low one cycle after done.
- fixed_en=1, fixed_val=2'b11 -> every record with class=1 has dut_in[3:2]=2'b11, while dut_in[1:0] still follows LFSR bits; class=0 records carry LFSR data bits.
- cap_ready held low 5 cycles in CAPTURE -> cap_valid and cap_data stable throughout, no LOAD, trace_cnt unchanged until ready rises.
- abort during SETTLE of trace 2 -> IDLE next cycle, dut_in=0, no done, trace_cnt=1; a later start clears the count and the LFSR continues (not reseeded).
- n_traces=0 -> exactly one trace then done; start and abort asserted together in IDLE -> busy stays 0.
